// File: rtl/reg_dump_scanner_if.sv
// Debug-readback bundle between reg_dump_scanner and its environment.
//   master : the scanner (drives address, status and dump stream)
//   slave  : Top debug port + golden loader + dump consumer
// Signals
//   start                          scan start pulse
//   address / value_i              debug address to Top, Top.value_o back
//   gold_we / gold_addr / gold_data golden table write port
//   busy / done / pass             scan status
//   err_cnt / first_err            scan result
//   dump_valid / dump_ready        per-word stream handshake
//   dump_addr / dump_data          stream payload
interface reg_dump_scanner_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
);
    logic              start;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] value_i;
    logic              gold_we;
    logic [ADDR_W-1:0] gold_addr;
    logic [DATA_W-1:0] gold_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        input  start, value_i, gold_we, gold_addr, gold_data, dump_ready,
        output address, busy, done, pass, err_cnt, first_err,
               dump_valid, dump_addr, dump_data
    );

    modport slave (
        output start, value_i, gold_we, gold_addr, gold_data, dump_ready,
        input  address, busy, done, pass, err_cnt, first_err,
               dump_valid, dump_addr, dump_data
    );
endinterface

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: post-run register readback engine.
// After start it waits WAIT_CYCLES, sweeps address 0..NUM_REGS-1 on Top's debug
// port, samples value_i RD_LAT cycles after each address change and compares it
// against an internally loaded golden table. Reports pass, a saturating error
// count and the index of the first mismatch.
// Optional feature macro: REG_DUMP_STREAM_EN -- when defined every sampled word
// is also offered on a valid/ready dump stream and the sweep stalls on it.
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous reset, active low
//   dbg   : reg_dump_scanner_if.master (debug bus, golden loader, status, dump)
module reg_dump_scanner #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int WAIT_CYCLES = 40,
    parameter int RD_LAT      = 1,
    parameter int CNT_W       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    reg_dump_scanner_if.master    dbg
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_CAPT, S_HOLD, S_DONE} state_e;

    localparam int TMR_MAX = (WAIT_CYCLES > RD_LAT) ? WAIT_CYCLES : RD_LAT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // WAIT_CYCLES==0 still spends the single entry cycle in WAIT.
    localparam logic [TMR_W-1:0]  WAIT_LAST  = TMR_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  RD_LAST    = TMR_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_X = (ADDR_W + 1)'(NUM_REGS);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;          // doubles as the debug address
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;
    logic                pass_q, pass_d;
    logic                start_ok, hold_release, mismatch, gold_wr;
    logic                busy, done;

    // Golden table: not reset, survives aborted scans.
    logic [DATA_W-1:0]   gold_q [2**IDX_W];

    assign start_ok = dbg.start && (state_q == S_IDLE || state_q == S_DONE);
    assign mismatch = (dbg.value_i != gold_q[idx_q[IDX_W-1:0]]);
    assign gold_wr  = dbg.gold_we && !busy && ({1'b0, dbg.gold_addr} < NUM_REGS_X);

`ifdef REG_DUMP_STREAM_EN
    logic                dump_valid_q, dump_valid_d;
    logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
    logic [DATA_W-1:0]   dump_data_q, dump_data_d;

    assign hold_release = dump_valid_q && dbg.dump_ready;
`else
    logic unused_dump_ready;
    assign unused_dump_ready = dbg.dump_ready;
    assign hold_release      = 1'b1;
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (dbg.start) state_d = S_WAIT;
            S_WAIT:         if (tmr_q == WAIT_LAST) state_d = S_ADDR;
            S_ADDR:         if (tmr_q == RD_LAST) state_d = S_CAPT;
            S_CAPT:         state_d = S_HOLD;
            S_HOLD:         if (hold_release) state_d = (idx_q == LAST_IDX) ? S_DONE : S_ADDR;
            default:        state_d = S_IDLE;
        endcase
    end

    // ---------------- outputs / datapath next values ----------------
    always_comb begin
        busy        = (state_q == S_WAIT) || (state_q == S_ADDR) ||
                      (state_q == S_CAPT) || (state_q == S_HOLD);
        done        = (state_q == S_DONE);
        tmr_d       = '0;
        idx_d       = idx_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        // Timer restarts on every state change so WAIT and ADDR each count from 0.
        if ((state_q == S_WAIT || state_q == S_ADDR) && state_d == state_q)
            tmr_d = tmr_q + 1'b1;

        if (start_ok) begin
            idx_d       = '0;
            err_cnt_d   = '0;
            first_err_d = '1;
            pass_d      = 1'b0;
        end

        if (state_q == S_CAPT && mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            // err_cnt never returns to zero within a scan, so zero marks the first miss.
            if (err_cnt_q == '0) first_err_d = idx_q;
        end

        if (state_q == S_HOLD && hold_release) begin
            if (idx_q == LAST_IDX) pass_d = (err_cnt_q == '0);
            else                   idx_d  = idx_q + 1'b1;
        end
    end

`ifdef REG_DUMP_STREAM_EN
    always_comb begin
        dump_valid_d = dump_valid_q;
        dump_addr_d  = dump_addr_q;
        dump_data_d  = dump_data_q;
        if (state_q == S_CAPT) begin
            dump_valid_d = 1'b1;
            dump_addr_d  = idx_q;
            dump_data_d  = dbg.value_i;
        end else if (dump_valid_q && dbg.dump_ready) begin
            dump_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dump_valid_q <= 1'b0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
        end else begin
            dump_valid_q <= dump_valid_d;
            dump_addr_q  <= dump_addr_d;
            dump_data_q  <= dump_data_d;
        end
    end

    assign dbg.dump_valid = dump_valid_q;
    assign dbg.dump_addr  = dump_addr_q;
    assign dbg.dump_data  = dump_data_q;
`else
    assign dbg.dump_valid = 1'b0;
    assign dbg.dump_addr  = '0;
    assign dbg.dump_data  = '0;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr_q       <= '0;
            idx_q       <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            pass_q      <= 1'b0;
        end else begin
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    always_ff @(posedge clk) begin
        if (gold_wr) gold_q[dbg.gold_addr[IDX_W-1:0]] <= dbg.gold_data;
    end

    assign dbg.address   = idx_q;
    assign dbg.busy      = busy;
    assign dbg.done      = done;
    assign dbg.pass      = pass_q;
    assign dbg.err_cnt   = err_cnt_q;
    assign dbg.first_err = first_err_q;
endmodule

// File: tb/tb_reg_dump_scanner.sv
module tb_reg_dump_scanner;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int WC = 40;
    localparam int RL = 1;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_dump_scanner_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dif ();

    reg_dump_scanner #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR),
        .WAIT_CYCLES(WC), .RD_LAT(RL), .CNT_W(CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dbg (dif)
    );

    typedef struct packed {
        logic          pass;
        logic [CW-1:0] err;
        logic [AW-1:0] first;
    } res_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } dump_t;

    res_t  res_q[$];
    dump_t dump_q[$];
    int    checks = 0;
    int    errors = 0;
    int    hs_cnt = 0;
    logic  seen_valid = 1'b0;

    logic [DW-1:0] top_regs [NR];
    logic [DW-1:0] gold_m   [NR];

    // Top model: one registered read stage (RD_LAT=1).
    always @(posedge clk) dif.value_i <= top_regs[dif.address[4:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_scan(input logic p, input logic [CW-1:0] e, input logic [AW-1:0] f);
        res_t r;
        r.pass  = p;
        r.err   = e;
        r.first = f;
        res_q.push_back(r);
`ifdef REG_DUMP_STREAM_EN
        for (int i = 0; i < NR; i++) begin
            dump_t dw;
            dw.a = AW'(i);
            dw.d = top_regs[i];
            dump_q.push_back(dw);
        end
`endif
    endtask

    task automatic pulse_start();
        @(negedge clk);
        dif.start = 1'b1;
        @(posedge clk);
        #1 dif.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!dif.done && n < 3000);
        if (!dif.done) chk("scan_timeout_done", {63'd0, dif.done}, 64'd1);
    endtask

    task automatic wait_addr(input logic [AW-1:0] a);
        int n = 0;
        @(negedge clk);
        while (dif.address != a && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (dif.address != a) chk("wait_addr_timeout", {54'd0, dif.address}, {54'd0, a});
    endtask

    // Result monitor: one expected entry per completed scan.
    initial begin : mon_done
        logic prev;
        res_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (dif.done && !prev) begin
                if (res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done=1 required no completed scan");
                end else begin
                    e = res_q.pop_front();
                    chk("pass",      {63'd0, dif.pass},      {63'd0, e.pass});
                    chk("err_cnt",   {61'd0, dif.err_cnt},   {61'd0, e.err});
                    chk("first_err", {54'd0, dif.first_err}, {54'd0, e.first});
                end
            end
            prev = dif.done;
        end
    end

    // Dump monitor: compares each handshake against the expected word order.
    initial begin : mon_dump
        dump_t e;
        forever begin
            @(negedge clk);
            #1;
            if (dif.dump_valid) seen_valid = 1'b1;
            if (dif.dump_valid && dif.dump_ready) begin
                hs_cnt++;
                if (dump_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dump_unexpected: got addr 0x%0h required no word", dif.dump_addr);
                end else begin
                    e = dump_q.pop_front();
                    chk("dump_addr", {54'd0, dif.dump_addr}, {54'd0, e.a});
                    chk("dump_data", {32'd0, dif.dump_data}, {32'd0, e.d});
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        dif.start      = 1'b0;
        dif.gold_we    = 1'b0;
        dif.gold_addr  = '0;
        dif.gold_data  = '0;
        dif.dump_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            gold_m[i]   = DW'(i) * 32'h1111_1111;
            top_regs[i] = gold_m[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      {63'd0, dif.busy},       64'd0);
        chk("rst_done",      {63'd0, dif.done},       64'd0);
        chk("rst_pass",      {63'd0, dif.pass},       64'd0);
        chk("rst_err_cnt",   {61'd0, dif.err_cnt},    64'd0);
        chk("rst_first_err", {54'd0, dif.first_err},  64'h3FF);
        chk("rst_address",   {54'd0, dif.address},    64'd0);
        chk("rst_dump_vld",  {63'd0, dif.dump_valid}, 64'd0);
        rst = 1'b1;

        // Golden load, plus an out-of-range write that must not alias onto index 8
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            dif.gold_we   = 1'b1;
            dif.gold_addr = AW'(i);
            dif.gold_data = gold_m[i];
        end
        @(negedge clk);
        dif.gold_addr = 10'd40;
        dif.gold_data = 32'hDEAD_BEEF;
        @(negedge clk);
        dif.gold_we = 1'b0;

        // 1: clean scan, exact latency WAIT + NR*(RD_LAT+2)
        push_scan(1'b1, 3'd0, 10'h3FF);
        pulse_start();
        chk("t1_busy", {63'd0, dif.busy}, 64'd1);
        wait_done(n);
        chk("t1_latency", 64'(n), 64'(WC + NR * (RL + 2)));
        chk("t1_addr_hold", {54'd0, dif.address}, 64'd31);
        chk("t1_busy_done", {63'd0, dif.busy}, 64'd0);

        // 2: two mismatches
        top_regs[5]  = gold_m[5] ^ 32'h1;
        top_regs[17] = gold_m[17] ^ 32'h8000_0000;
        push_scan(1'b0, 3'd2, 10'd5);
        pulse_start();
        wait_done(n);
        top_regs[5]  = gold_m[5];
        top_regs[17] = gold_m[17];

        // 3: all mismatch, err_cnt saturates at 7
        for (int i = 0; i < NR; i++) top_regs[i] = ~gold_m[i];
        push_scan(1'b0, 3'd7, 10'd0);
        pulse_start();
        wait_done(n);
        for (int i = 0; i < NR; i++) top_regs[i] = gold_m[i];

        // 6: start + gold_we mid-scan are ignored
        top_regs[9] = gold_m[9] ^ 32'h00FF_0000;
        push_scan(1'b0, 3'd1, 10'd9);
        pulse_start();
        wait_addr(10'd8);
        dif.start     = 1'b1;
        dif.gold_we   = 1'b1;
        dif.gold_addr = 10'd9;
        dif.gold_data = top_regs[9];
        @(posedge clk);
        #1;
        dif.start   = 1'b0;
        dif.gold_we = 1'b0;
        @(negedge clk);
        chk("t6_busy", {63'd0, dif.busy}, 64'd1);
        chk("t6_addr", {54'd0, dif.address}, 64'd8);
        wait_done(n);
        top_regs[9] = gold_m[9];

        // 4: stream with a 10-cycle stall at idx 3
        push_scan(1'b1, 3'd0, 10'h3FF);
        hs_cnt = 0;
        pulse_start();
`ifdef REG_DUMP_STREAM_EN
        n = 0;
        @(negedge clk);
        while (!(dif.dump_valid && dif.dump_addr == 10'd3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        dif.dump_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_stall_valid", {63'd0, dif.dump_valid}, 64'd1);
            chk("t4_stall_daddr", {54'd0, dif.dump_addr},  64'd3);
            chk("t4_stall_data",  {32'd0, dif.dump_data},  {32'd0, gold_m[3]});
            chk("t4_stall_addr",  {54'd0, dif.address},    64'd3);
        end
        dif.dump_ready = 1'b1;
`endif
        wait_done(n);
        @(negedge clk);
`ifdef REG_DUMP_STREAM_EN
        chk("t4_handshakes", 64'(hs_cnt), 64'd32);
`else
        chk("t4_no_dump_valid", {63'd0, seen_valid}, 64'd0);
        chk("t4_dump_data0", {32'd0, dif.dump_data}, 64'd0);
`endif

        // 5: reset during ADDR at idx 12, then a full clean rescan
        top_regs[3] = gold_m[3] ^ 32'h10;
        pulse_start();
        wait_addr(10'd12);
        chk("t5_pre_err", {61'd0, dif.err_cnt}, 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_busy",      {63'd0, dif.busy},       64'd0);
        chk("t5_done",      {63'd0, dif.done},       64'd0);
        chk("t5_pass",      {63'd0, dif.pass},       64'd0);
        chk("t5_err_cnt",   {61'd0, dif.err_cnt},    64'd0);
        chk("t5_first_err", {54'd0, dif.first_err},  64'h3FF);
        chk("t5_address",   {54'd0, dif.address},    64'd0);
        chk("t5_dump_vld",  {63'd0, dif.dump_valid}, 64'd0);
        dump_q.delete();
        top_regs[3] = gold_m[3];
        push_scan(1'b1, 3'd0, 10'h3FF);
        pulse_start();
        wait_done(n);

        repeat (3) @(negedge clk);
        chk("sb_res_drain",  64'(res_q.size()),  64'd0);
        chk("sb_dump_drain", 64'(dump_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
